// File: rtl/reg_file_pkg.sv
// Shared constants for the register file slice: default geometry and the zero-register index.
package reg_file_pkg;

    localparam int unsigned RF_DATA_WIDTH  = 32;
    localparam int unsigned RF_ADDR_WIDTH  = 5;
    localparam int unsigned RF_NUM_REGS    = 32;
    localparam int unsigned REG_ZERO       = 0;
    localparam int unsigned WR_COUNT_WIDTH = 16;

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: two operand read ports, one write port, zero flag, debug read, write counter.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0]     rs1_addr;
    logic [ADDR_WIDTH-1:0]     rs2_addr;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      flag_we;
    logic                      z_in;
    logic                      z_flag_q;
    logic [ADDR_WIDTH-1:0]     dbg_addr;
    logic [DATA_WIDTH-1:0]     dbg_data;
    logic [WR_COUNT_WIDTH-1:0] wr_count;

    // Core / test logic side.
    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, flag_we, z_in, dbg_addr,
        input  rs1_data, rs2_data, z_flag_q, dbg_data, wr_count
    );

    // Register file side.
    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, flag_we, z_in, dbg_addr,
        output rs1_data, rs2_data, z_flag_q, dbg_data, wr_count
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: index decode, zero/out-of-range masking and write-through bypass.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = RF_NUM_REGS
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
    output logic [DATA_WIDTH-1:0] data
);

    localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic            addr_valid;
    logic            bypass_hit;
    logic [IdxW-1:0] idx;

    assign addr_valid = (addr != ADDR_WIDTH'(REG_ZERO)) && (32'(addr) < NUM_REGS);
    assign bypass_hit = wr_en && (addr == wr_addr);
    assign idx        = addr[IdxW-1:0];

    // Bypass beats the array so a write is visible in the cycle it is issued.
    always_comb begin
        data = '0;
        if (addr_valid) begin
            data = bypass_hit ? wr_data : regs[idx];
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 2 operand read ports, 1 write port, debug read port,
// sticky zero flag and a saturating committed-write counter.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = RF_NUM_REGS
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave bus
);

    localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
    logic                      flag_q;
    logic [WR_COUNT_WIDTH-1:0] count_q;
    logic                      wr_commit;
    logic [IdxW-1:0]           wr_idx;

    // Writes to r0 or beyond NUM_REGS are dropped and never counted.
    assign wr_commit = bus.wr_en && (bus.wr_addr != ADDR_WIDTH'(REG_ZERO)) &&
                       (32'(bus.wr_addr) < NUM_REGS);
    assign wr_idx    = bus.wr_addr[IdxW-1:0];

    // Register array; r0 is never written so it stays zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wr_idx] <= bus.wr_data;
        end
    end

    // Sticky zero flag, captured only when flag_we is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else if (bus.flag_we) begin
            flag_q <= bus.z_in;
        end
    end

    // Committed-write counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (wr_commit && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.z_flag_q = flag_q;
    assign bus.wr_count = count_q;

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rs1_port (
        .addr    (bus.rs1_addr),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .regs    (regs_q),
        .data    (bus.rs1_data)
    );

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rs2_port (
        .addr    (bus.rs2_addr),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .regs    (regs_q),
        .data    (bus.rs2_data)
    );

    reg_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_dbg_port (
        .addr    (bus.dbg_addr),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .regs    (regs_q),
        .data    (bus.dbg_data)
    );

endmodule
